// File: rtl/sev_seg_scan_ctrl.sv
// sev_seg_scan_ctrl: time-multiplexed scan controller for a common-anode display.
// Steps through NUM_DIGITS slots, each a GUARD gap (all anodes off) followed by a SHOW
// window. It presents the active value's nibble for the current slot and drives the
// active-low anode selects.
// Optional build macro: LEADING_ZERO_BLANK_EN keeps digits above the most-significant
// nonzero nibble dark. Digit 0 is always lit.
module sev_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                          BrdClk,
  input  logic                          aReset_n,
  input  logic [4*NUM_DIGITS-1:0]       bValue,
  input  logic                          bLoad,
  input  logic [NUM_DIGITS-1:0]         bDigitEn,
  output logic [3:0]                    bNibble,
  output logic [NUM_DIGITS-1:0]         bDigitSel,
  output logic [$clog2(NUM_DIGITS)-1:0] bDigitIdx,
  output logic                          bFrameDone
);

  localparam int unsigned CntMax = (TICK_DIV > GUARD_CYCLES) ? TICK_DIV : GUARD_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] GuardLast = CntW'(GUARD_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(TICK_DIV - 1);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StGuard, StShow} state_e;

  state_e                       state_q, state_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]   active_q, active_d;
  logic [NUM_DIGITS-1:0][3:0]   pending_q, pending_d;
  logic                         pendValid_q, pendValid_d;
  logic                         frameDone_q, frameDone_d;
  logic                         wrap;
  logic [NUM_DIGITS-1:0]        shownMask;

  // Slot sequencing: GUARD for GUARD_CYCLES clocks, then SHOW for TICK_DIV clocks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    wrap    = 1'b0;
    unique case (state_q)
      StGuard: begin
        if (cnt_q == GuardLast) begin
          state_d = StShow;
          cnt_d   = '0;
        end
      end
      StShow: begin
        if (cnt_q == ShowLast) begin
          state_d = StGuard;
          cnt_d   = '0;
          wrap    = (idx_q == LastIdx);
          idx_d   = wrap ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = StGuard;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Value double-buffer: loads land in pending; active only changes at the frame wrap.
  always_comb begin
    active_d    = active_q;
    pending_d   = pending_q;
    pendValid_d = pendValid_q;
    frameDone_d = wrap;
    if (wrap) begin
      // A load coinciding with the wrap bypasses pending and supersedes it.
      if (bLoad) begin
        active_d = bValue;
      end else if (pendValid_q) begin
        active_d = pending_q;
      end
      pendValid_d = 1'b0;
    end else if (bLoad) begin
      pending_d   = bValue;
      pendValid_d = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Light a digit only if it or some higher digit of active is nonzero; digit 0 always lit.
  always_comb begin
    logic seenNz;
    seenNz    = 1'b0;
    shownMask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seenNz       = seenNz | (active_q[i] != 4'h0);
      shownMask[i] = seenNz;
    end
    shownMask[0] = 1'b1;
  end
`else
  assign shownMask = '1;
`endif

  // Outputs decoded from current state; the nibble leads the anode by the guard gap.
  always_comb begin
    bDigitSel = '1;
    if (state_q == StShow) begin
      bDigitSel[idx_q] = ~(bDigitEn[idx_q] & shownMask[idx_q]);
    end
    bNibble    = active_q[idx_q];
    bDigitIdx  = idx_q;
    bFrameDone = frameDone_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge BrdClk) begin
    if (!aReset_n) begin
      state_q     <= StGuard;
      cnt_q       <= '0;
      idx_q       <= '0;
      active_q    <= '0;
      pending_q   <= '0;
      pendValid_q <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      pendValid_q <= pendValid_d;
      frameDone_q <= frameDone_d;
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Directed bench for sev_seg_scan_ctrl with NUM_DIGITS=8, TICK_DIV=4, GUARD_CYCLES=2.
// Slot k of a frame starting at cycle F: guard F+6k..F+6k+1, show F+6k+2..F+6k+5.
module tb_sev_seg_scan_ctrl;

  logic        BrdClk   = 1'b0;
  logic        aReset_n = 1'b0;
  logic [31:0] bValue   = '0;
  logic        bLoad    = 1'b0;
  logic [7:0]  bDigitEn = 8'hFF;
  logic [3:0]  bNibble;
  logic [7:0]  bDigitSel;
  logic [2:0]  bDigitIdx;
  logic        bFrameDone;

  int unsigned nVec = 0;
  int unsigned nMis = 0;
  int unsigned cyc  = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam int unsigned LitZero = 1;
  localparam int unsigned LitA07  = 3;
`else
  localparam int unsigned LitZero = 8;
  localparam int unsigned LitA07  = 8;
`endif

  logic [7:0] selOne [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [3:0] nib89  [8] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};
  logic [3:0] nibA07 [8] = '{4'h7, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [7:0] selAA  [8] = '{8'hFF, 8'hFD, 8'hFF, 8'hF7, 8'hFF, 8'hDF, 8'hFF, 8'h7F};

  sev_seg_scan_ctrl #(
    .NUM_DIGITS  (8),
    .TICK_DIV    (4),
    .GUARD_CYCLES(2)
  ) dut (
    .BrdClk    (BrdClk),
    .aReset_n  (aReset_n),
    .bValue    (bValue),
    .bLoad     (bLoad),
    .bDigitEn  (bDigitEn),
    .bNibble   (bNibble),
    .bDigitSel (bDigitSel),
    .bDigitIdx (bDigitIdx),
    .bFrameDone(bFrameDone)
  );

  always #5 BrdClk = ~BrdClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge BrdClk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int unsigned t);
    if (t < cyc) begin
      nVec++;
      nMis++;
      $display("FAIL runTo at cyc %0d: got %0d want %0d", cyc, cyc, t);
    end
    while (cyc < t) tick();
  endtask

  // Present bValue with bLoad for the current window; it is sampled at the next edge.
  task automatic load(input logic [31:0] v);
    bValue = v;
    bLoad  = 1'b1;
    tick();
    bLoad  = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    repeat (3) tick();
    chk("rst_sel", bDigitSel, 8'hFF);
    chk("rst_nib", bNibble, 4'h0);
    chk("rst_idx", bDigitIdx, 3'd0);
    chk("rst_fd", bFrameDone, 1'b0);
    aReset_n = 1'b1;
    cyc      = 0;

    // Startup slot timing
    chk("g0_sel", bDigitSel, 8'hFF);
    runTo(1); chk("g1_sel", bDigitSel, 8'hFF);
    runTo(2); chk("s0_sel", bDigitSel, 8'hFE); chk("s0_nib", bNibble, 4'h0);
    runTo(5); chk("s0e_sel", bDigitSel, 8'hFE);
    runTo(6); chk("g1d_sel", bDigitSel, 8'hFF); chk("g1d_idx", bDigitIdx, 3'd1);

    // Load during digit 3 must not tear the current frame
    runTo(20); load(32'h89AB_CDEF);
    runTo(30); chk("tear_nib", bNibble, 4'h0); chk("tear_idx", bDigitIdx, 3'd5);
    runTo(47); chk("pre_fd", bFrameDone, 1'b0); chk("pre_idx", bDigitIdx, 3'd7);
    chk("pre_nib", bNibble, 4'h0);
    runTo(48); chk("fd1", bFrameDone, 1'b1); chk("fd1_sel", bDigitSel, 8'hFF);
    chk("fd1_nib", bNibble, 4'hF); chk("fd1_idx", bDigitIdx, 3'd0);
    runTo(49); chk("fd1_off", bFrameDone, 1'b0);
    for (int k = 0; k < 8; k++) begin
      runTo(50 + 6 * k);
      chk("f1_sel", bDigitSel, selOne[k]);
      chk("f1_nib", bNibble, nib89[k]);
    end

    // Two loads in frame 3: last wins, applied at the next wrap
    runTo(100); load(32'h1111_1111);
    runTo(110); load(32'h2222_2222);
    runTo(122); chk("f3_nib", bNibble, 4'hB);
    runTo(144); chk("fd3", bFrameDone, 1'b1); chk("f4_nib0", bNibble, 4'h2);
    runTo(146); chk("f4_nib1", bNibble, 4'h2);
    runTo(186); chk("f4_nib7", bNibble, 4'h2);

    // Load exactly on the wrap cycle (last SHOW cycle of digit 7) bypasses to active
    runTo(191); load(32'h3333_3333);
    chk("wrap_fd", bFrameDone, 1'b1); chk("wrap_nib", bNibble, 4'h3);
    runTo(194); chk("wrap_nib2", bNibble, 4'h3);

    // Enable mask: odd digits only; frame period unchanged
    bDigitEn = 8'b1010_1010;
    for (int k = 0; k < 8; k++) begin
      runTo(195 + 6 * k);
      chk("en_sel", bDigitSel, selAA[k]);
    end
    runTo(239); chk("en_fd0", bFrameDone, 1'b0);
    runTo(240); chk("en_fd1", bFrameDone, 1'b1); chk("en_nib", bNibble, 4'h3);
    bDigitEn = 8'hFF;

    // Reset during SHOW of digit 5 with a pending load outstanding
    runTo(250); load(32'h4444_4444);
    runTo(273); chk("r5_idx", bDigitIdx, 3'd5); chk("r5_sel", bDigitSel, 8'hDF);
    aReset_n = 1'b0;
    tick();
    chk("r5r_sel", bDigitSel, 8'hFF); chk("r5r_idx", bDigitIdx, 3'd0);
    chk("r5r_nib", bNibble, 4'h0); chk("r5r_fd", bFrameDone, 1'b0);
    aReset_n = 1'b1;
    cyc      = 0;

    // Value 0: blanking depends on build option
    for (int k = 0; k < 8; k++) begin
      runTo(2 + 6 * k);
      e = (k < LitZero) ? selOne[k] : 8'hFF;
      chk("z_sel", bDigitSel, e);
    end
    // Pending must have been cleared by reset
    runTo(48); chk("z_fd", bFrameDone, 1'b1); chk("z_nib", bNibble, 4'h0);

    // Value 0x00000A07
    runTo(60); load(32'h0000_0A07);
    for (int k = 0; k < 8; k++) begin
      runTo(98 + 6 * k);
      e = (k < LitA07) ? selOne[k] : 8'hFF;
      chk("a07_sel", bDigitSel, e);
      chk("a07_nib", bNibble, nibA07[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
